// File: rtl/zoom_frame_sequencer.sv
// zoom_frame_sequencer
//
// Walks one full destination frame in raster order and, for every destination pixel, either
// fetches source pixels from the ROM (copy, replicate, decimate or block average) or writes
// background zero. Runs are triggered by a rising edge of `enable` from the zoom controller;
// `done` pulses for one cycle after the last pixel has been written.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   enable           run request, held high for the whole run; dropping it aborts the run
//   zoom_level       0=0.25x 1=0.5x 2=1x 3=2x 4=4x (5..7 behave as 2), latched at start
//   algorithm_select 00/01 replicate, 10 decimate, 11 block average, latched at start
//   rom_addr         source read address (held outside ISSUE)
//   rom_data         source data, valid RD_LAT cycles after rom_addr
//   wr_addr          destination write address (dy*DST_W+dx)
//   wr_data          destination write data
//   wr_en            destination write strobe
//   busy             high in every state except IDLE
//   done             one-cycle completion pulse
module zoom_frame_sequencer #(
  parameter int unsigned SRC_W  = 160,
  parameter int unsigned SRC_H  = 120,
  parameter int unsigned DST_W  = 640,
  parameter int unsigned DST_H  = 480,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned SRC_AW = 15,
  parameter int unsigned DST_AW = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        zoom_level,
  input  logic [1:0]        algorithm_select,
  output logic [SRC_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DST_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW   = $clog2(DST_W);
  localparam int unsigned YW   = $clog2(DST_H);
  localparam int unsigned AccW = DATA_W + 4;

  localparam logic [XW-1:0] XLast    = XW'(DST_W - 1);
  localparam logic [YW-1:0] YLast    = YW'(DST_H - 1);
  localparam logic [1:0]    WaitLast = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_e;
  typedef enum logic [1:0] {ModeCopy, ModeRep, ModeDec, ModeAvg} mode_e;

  state_e            state_q;
  mode_e             mode_q;
  logic [1:0]        k_q;
  logic              en_q;
  logic [XW-1:0]     dx_q;
  logic [YW-1:0]     dy_q;
  logic [DST_AW-1:0] pix_q;
  logic [4:0]        rd_q;
  logic [1:0]        wait_q;
  logic [AccW-1:0]   acc_q;

  // Source address of read `rd` for destination pixel (x, y).
  function automatic logic [SRC_AW-1:0] src_addr(input logic [31:0] x, input logic [31:0] y,
                                                 input logic [4:0] rd, input mode_e m,
                                                 input logic [1:0] k);
    logic [31:0] sx, sy, mask;
    mask = (32'd1 << k) - 32'd1;
    case (m)
      ModeRep: begin
        sx = x >> k;
        sy = y >> k;
      end
      ModeDec: begin
        sx = x << k;
        sy = y << k;
      end
      ModeAvg: begin
        // Block offsets walk the 2^k x 2^k block in row-major order.
        sx = (x << k) + (32'(rd) & mask);
        sy = (y << k) + (32'(rd) >> k);
      end
      default: begin
        sx = x;
        sy = y;
      end
    endcase
    return SRC_AW'(sy * SRC_W + sx);
  endfunction

  logic [2:0]        lvl;
  mode_e             start_mode;
  logic [1:0]        start_k;
  logic              start;
  logic [31:0]       img_w, img_h;
  logic              x_last, frame_last;
  logic [XW-1:0]     nx;
  logic [YW-1:0]     ny;
  logic              nxt_is_img;
  logic [4:0]        rd_last;
  logic [AccW-1:0]   acc_sum;
  logic [SRC_AW-1:0] nxt_addr, rd_addr;

  always_comb begin
    lvl        = (zoom_level > 3'd4) ? 3'd2 : zoom_level;
    start_mode = ModeCopy;
    start_k    = 2'd0;
    if (lvl > 3'd2) begin
      start_mode = ModeRep;
      start_k    = 2'(lvl - 3'd2);
    end else if (lvl < 3'd2) begin
      start_mode = (algorithm_select == 2'b11) ? ModeAvg : ModeDec;
      start_k    = 2'(3'd2 - lvl);
    end
    start = (state_q == StIdle) && enable && !en_q;

    img_w = SRC_W;
    img_h = SRC_H;
    case (mode_q)
      ModeRep: begin
        img_w = SRC_W << k_q;
        img_h = SRC_H << k_q;
      end
      ModeDec, ModeAvg: begin
        img_w = SRC_W >> k_q;
        img_h = SRC_H >> k_q;
      end
      default: ;
    endcase

    x_last     = (dx_q == XLast);
    frame_last = x_last && (dy_q == YLast);
    nx         = x_last ? '0 : dx_q + 1'b1;
    ny         = x_last ? dy_q + 1'b1 : dy_q;
    nxt_is_img = (32'(nx) < img_w) && (32'(ny) < img_h);

    rd_last  = (mode_q == ModeAvg) ? ((5'd1 << {k_q, 1'b0}) - 5'd1) : 5'd0;
    acc_sum  = acc_q + {4'b0000, rom_data};
    nxt_addr = src_addr(32'(nx), 32'(ny), 5'd0, mode_q, k_q);
    rd_addr  = src_addr(32'(dx_q), 32'(dy_q), rd_q + 5'd1, mode_q, k_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= ModeCopy;
      k_q      <= '0;
      en_q     <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      pix_q    <= '0;
      rd_q     <= '0;
      wait_q   <= '0;
      acc_q    <= '0;
      rom_addr <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      en_q <= enable;
      case (state_q)
        StIdle: begin
          if (start) begin
            mode_q   <= start_mode;
            k_q      <= start_k;
            dx_q     <= '0;
            dy_q     <= '0;
            pix_q    <= '0;
            rd_q     <= '0;
            wait_q   <= '0;
            acc_q    <= '0;
            // Pixel (0,0) is inside the image in every mode and always reads source (0,0).
            rom_addr <= '0;
            busy     <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (!enable) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            wait_q  <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!enable) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (wait_q == WaitLast) begin
            acc_q <= acc_sum;
            if (rd_q == rd_last) begin
              wr_en   <= 1'b1;
              wr_addr <= pix_q;
              wr_data <= (mode_q == ModeAvg) ? DATA_W'(acc_sum >> {k_q, 1'b0}) : rom_data;
              state_q <= StWrite;
            end else begin
              rd_q     <= rd_q + 5'd1;
              rom_addr <= rd_addr;
              state_q  <= StIssue;
            end
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        StWrite: begin
          if (!enable) begin
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (frame_last) begin
            wr_en   <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            dx_q  <= nx;
            dy_q  <= ny;
            pix_q <= pix_q + 1'b1;
            rd_q  <= '0;
            acc_q <= '0;
            if (nxt_is_img) begin
              wr_en    <= 1'b0;
              rom_addr <= nxt_addr;
              state_q  <= StIssue;
            end else begin
              // Background pixel: straight to another write of zero, no ROM access.
              wr_en   <= 1'b1;
              wr_addr <= pix_q + 1'b1;
              wr_data <= '0;
              state_q <= StWrite;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          wr_en   <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_frame_sequencer.sv
module tb_zoom_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] zoom_level;
  logic [1:0] algorithm_select;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       done;

  logic [7:0] src_mem [16];
  logic [7:0] dest [256];
  logic [3:0] rom_log [$];

  int n_checks = 0;
  int n_errors = 0;
  int cycles, writes, first_wa, post_abort_wr, busy_after_abort, done_seen, busy_hold;

  zoom_frame_sequencer #(
    .SRC_W (4),
    .SRC_H (4),
    .DST_W (16),
    .DST_H (16),
    .DATA_W(8),
    .RD_LAT(1),
    .SRC_AW(4),
    .DST_AW(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .zoom_level      (zoom_level),
    .algorithm_select(algorithm_select),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_en           (wr_en),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency source ROM.
  always_ff @(posedge clk) rom_data <= src_mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rom_addr"}, 32'(rom_addr), 0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  // Runs one frame starting from IDLE. Cycle 0 is the first ISSUE cycle.
  task automatic run_frame(input logic [2:0] lvl, input logic [1:0] alg, input int abort_at,
                           input int change_at, input int max_cyc);
    for (int i = 0; i < 256; i++) dest[i] = 8'hEE;
    rom_log.delete();
    cycles = -1; writes = 0; first_wa = -1; post_abort_wr = 0;
    busy_after_abort = -1; done_seen = 0; busy_hold = -1;
    zoom_level = lvl;
    algorithm_select = alg;
    enable = 1'b1;
    @(negedge clk);
    for (int c = 0; c < max_cyc; c++) begin
      if (busy && (rom_log.size() == 0 || rom_log[$] != rom_addr)) rom_log.push_back(rom_addr);
      if (wr_en) begin
        if (first_wa < 0) first_wa = int'(wr_addr);
        if (abort_at >= 0 && c > abort_at) post_abort_wr++;
        dest[wr_addr] = wr_data;
        writes++;
      end
      if (abort_at >= 0 && c == abort_at + 1) busy_after_abort = int'(busy);
      if (done) begin
        done_seen = 1;
        cycles = c;
        break;
      end
      if (c == abort_at) enable = 1'b0;
      if (c == change_at) begin
        zoom_level = 3'd0;
        algorithm_select = 2'b11;
      end
      @(negedge clk);
    end
    // Enable still high after completion must not start another run.
    repeat (3) @(negedge clk);
    busy_hold = int'(busy);
    enable = 1'b0;
    @(negedge clk);
  endtask

  // kind: 0 copy, 1 replicate 4x, 2 average 4x4 block, 3 decimate by 2
  task automatic check_frame(input string name, input int kind);
    int exp;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        case (kind)
          0: exp = (x < 4 && y < 4) ? int'(src_mem[y * 4 + x]) : 0;
          1: exp = int'(src_mem[(y / 4) * 4 + x / 4]);
          2: exp = (x == 0 && y == 0) ? 11 : 0;
          default: exp = (x < 2 && y < 2) ? int'(src_mem[(2 * y) * 4 + 2 * x]) : 0;
        endcase
        check_eq($sformatf("%s_px_%0d_%0d", name, x, y), 32'(dest[y * 16 + x]), 32'(exp));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    zoom_level = 3'd0;
    algorithm_select = 2'b00;
    for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Copy at 1x.
    run_frame(3'd2, 2'b00, -1, -1, 1000);
    check_eq("copy_cycles", 32'(cycles), 288);
    check_eq("copy_writes", 32'(writes), 256);
    check_eq("copy_first_wa", 32'(first_wa), 0);
    check_eq("copy_no_restart", 32'(busy_hold), 0);
    check_eq("copy_done_pulse", 32'(done), 0);
    check_frame("copy", 0);

    // Replicate 4x; level/algorithm changes mid-run must be ignored.
    run_frame(3'd4, 2'b00, -1, 20, 2000);
    check_eq("rep_cycles", 32'(cycles), 768);
    check_eq("rep_writes", 32'(writes), 256);
    check_eq("rep_dest_5_9", 32'(dest[9 * 16 + 5]), 9);
    check_frame("rep", 1);

    // Out-of-range level behaves as copy.
    run_frame(3'd7, 2'b11, -1, -1, 1000);
    check_eq("lvl7_cycles", 32'(cycles), 288);
    check_frame("lvl7", 0);

    // Block average 0.25x.
    for (int i = 0; i < 16; i++) src_mem[i] = 8'd10;
    src_mem[0] = 8'd26;
    run_frame(3'd0, 2'b11, -1, -1, 1000);
    check_eq("avg_cycles", 32'(cycles), 288);
    check_eq("avg_writes", 32'(writes), 256);
    check_eq("avg_log_len", 32'(rom_log.size()), 16);
    check_frame("avg", 2);

    // Decimate 0.5x.
    for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
    run_frame(3'd1, 2'b10, -1, -1, 1000);
    check_eq("dec_cycles", 32'(cycles), 264);
    check_eq("dec_log_len", 32'(rom_log.size()), 4);
    if (rom_log.size() == 4) begin
      check_eq("dec_addr0", 32'(rom_log[0]), 0);
      check_eq("dec_addr1", 32'(rom_log[1]), 2);
      check_eq("dec_addr2", 32'(rom_log[2]), 8);
      check_eq("dec_addr3", 32'(rom_log[3]), 10);
    end
    check_eq("dec_dest_1_1", 32'(dest[1 * 16 + 1]), 10);
    check_frame("dec", 3);

    // Abort by dropping enable at cycle 50, then restart.
    run_frame(3'd2, 2'b00, 50, -1, 400);
    check_eq("abort_no_done", 32'(done_seen), 0);
    check_eq("abort_busy", 32'(busy_after_abort), 0);
    check_eq("abort_no_wr", 32'(post_abort_wr), 0);
    run_frame(3'd2, 2'b00, -1, -1, 1000);
    check_eq("restart_first_wa", 32'(first_wa), 0);
    check_eq("restart_cycles", 32'(cycles), 288);

    // Reset during the WAIT of pixel (2,0): cycle 7 after the first ISSUE.
    zoom_level = 3'd2;
    algorithm_select = 2'b00;
    enable = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("midwait_busy", 32'(busy), 1);
    check_eq("midwait_rom_addr", 32'(rom_addr), 2);
    check_eq("midwait_wr_addr", 32'(wr_addr), 1);
    check_eq("midwait_wr_data", 32'(wr_data), 1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
